reuse_sampler_param: RTL and testbench
======================================

REUSE_SAMPLER_PARAM -- requirements
Module: reuse_sampler_param

Interface
REQ-001 SHALL have parameter N_TABLE, default 16, number of live-tracking table entries (power of two, 4..64).
REQ-002 SHALL have parameter BW_TAG, default 20, tag width.
REQ-003 SHALL have parameter N_FIFO, default 16, output record FIFO depth (power of two).
REQ-004 SHALL have parameter BW_PERIOD, default 9, sampling threshold width.
REQ-005 SHALL have port clock_i, input, 1, single clock, all state on rising edge.
REQ-006 SHALL have port resetn_i, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port en_i, input, 1, sampling enable; when low, no counting, sampling, or emission.
REQ-008 SHALL have port mode_i, input, 1, threshold source: 0 = fixed period_i, 1 = 16-bit LFSR low BW_PERIOD bits.
REQ-009 SHALL have port period_i, input, BW_PERIOD, fixed sampling threshold.
REQ-010 SHALL have ports req_i (1), pc_i (32), tag_i (BW_TAG), inputs, memory reference strobe, PC, and tag.
REQ-011 SHALL have port flush_i, input, 1, pulse requesting write-out of all live entries.
REQ-012 SHALL have port stall_o, output, 1, high means req_i is not accepted and the requester holds it.
REQ-013 SHALL have ports out_valid_o (1) and out_ready_i (1), output and input, record handshake.
REQ-014 SHALL have ports out_pc_o (32), out_tag_o (BW_TAG), out_interval_o (32, signed), out_time_o (32), outputs, record fields.
REQ-015 SHALL have ports count_o (32), fifo_level_o (log2(N_FIFO)+1) and flush_done_o (1), outputs, totals and status.

Function
REQ-016 SHALL implement FSM states RUN, EVICT_SCAN, FLUSH; stall_o = (state != RUN) | fifo_full.
REQ-017 SHALL accept a reference when req_i & en_i & !stall_o; all following per-reference actions occur in that single cycle.
REQ-018 SHALL first increment every valid entry counter, saturating at 32'h7FFFFFFF.
REQ-019 SHALL compare tag_i against valid entries only; at most one entry matches by construction.
REQ-020 on hit SHALL push {pc, tag, counter, time_cnt} to the FIFO, invalidate the entry and increment count_o.
REQ-021 SHALL keep time_cnt, incrementing it after every accepted reference and wrapping modulo 2^32.
REQ-022 sampling SHALL occur when samp_cnt == threshold: samp_cnt <= 0 and the LFSR advances; otherwise samp_cnt += 1.
REQ-023 on sampling SHALL load the lowest-index free entry (a slot freed by the same-cycle hit is eligible) with tag_i, pc_i, counter 0, valid 1.
REQ-024 if sampling finds no free entry, SHALL latch tag_i and pc_i as pending and go to EVICT_SCAN.
REQ-025 EVICT_SCAN SHALL scan one entry per cycle over N_TABLE cycles, tracking the maximum counter (lowest index wins ties).
REQ-026 EVICT_SCAN SHALL then, when the FIFO is not full, push the victim with interval = -counter (two's complement), increment count_o, load the pending entry at the victim index, and return to RUN.
REQ-027 on flush_i in RUN, SHALL enter FLUSH and walk indices 0..N_TABLE-1, one per cycle.
REQ-028 in FLUSH, each valid entry SHALL be pushed with a negated interval and invalidated; the walk holds while the FIFO is full.
REQ-029 SHALL pulse flush_done_o for one cycle after the last index and return to RUN.
REQ-030 SHALL ignore flush_i outside RUN.
REQ-031 FIFO SHALL be first-word fall-through; a pop occurs on out_valid_o & out_ready_i.
REQ-032 a simultaneous push and pop when full SHALL be disallowed; stall_o already blocks the push.
REQ-033 en_i low SHALL freeze all state except FIFO pops.
REQ-034 a change of mode_i or period_i SHALL take effect at the next comparison, without resetting samp_cnt.

Reset
REQ-035 on resetn_i low, SHALL clear all valid bits, counters, samp_cnt, time_cnt, count_o, the FIFO and pending regs, and set state RUN.
REQ-036 on resetn_i low, SHALL drive out_valid_o, stall_o and flush_done_o to 0.
REQ-037 on resetn_i low, SHALL set the LFSR to 16'hACE1.
REQ-038 reset asserted mid-EVICT_SCAN or mid-FLUSH SHALL abandon the operation with no record emitted.

Verification
REQ-039 mode 0, period 0, tags A,B,A with pc 0x10,0x20,0x10 -> one record {0x10, A, 2, time 2}; count_o=1.
REQ-040 N_TABLE=4, period 0, five distinct tags -> stall_o high N_TABLE+1 cycles; record {tag0, interval -4}; tag4 resident.
REQ-041 three live entries with counters 5,3,1, flush_i -> three negated records in index order, then flush_done_o pulse, table empty.
REQ-042 out_ready_i held 0 until FIFO full (16 records) -> stall_o=1, the next req_i is not counted; one pop deasserts stall_o.
REQ-043 mode 1, period ignored -> inter-sample gaps match the LFSR sequence from seed 16'hACE1; en_i low freezes samp_cnt.
REQ-044 reset pulsed during EVICT_SCAN -> all outputs 0 the next cycle, and no record appears.

Source files
------------

// File: rtl/reuse_sampler_param.sv
// Reuse-distance sampler: sampled references live in a small table until the tag is
// re-referenced, evicted or flushed, each event emitting {pc, tag, interval, time}.

module reuse_sampler_entry #(
   parameter int BW_TAG = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc,
   input  logic              load,
   input  logic              clr,
   input  logic [BW_TAG-1:0] ld_tag,
   input  logic [31:0]       ld_pc,
   input  logic [BW_TAG-1:0] cmp_tag,
   output logic              valid,
   output logic [BW_TAG-1:0] tag,
   output logic [31:0]       pc,
   output logic [31:0]       cnt,
   output logic              match
);
   // load beats clr so a slot freed by a hit can be refilled in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0; tag <= '0; pc <= '0; cnt <= '0;
      end else if (load) begin
         valid <= 1'b1; tag <= ld_tag; pc <= ld_pc; cnt <= '0;
      end else begin
         if (clr) valid <= 1'b0;
         if (inc && valid && cnt != 32'h7FFF_FFFF) cnt <= cnt + 32'd1;
      end
   end

   assign match = valid && (tag == cmp_tag);
endmodule

module reuse_sampler_param #(
   parameter int N_TABLE   = 16,
   parameter int BW_TAG    = 20,
   parameter int N_FIFO    = 16,
   parameter int BW_PERIOD = 9
) (
   input  logic                   clock_i,
   input  logic                   resetn_i,
   input  logic                   en_i,
   input  logic                   mode_i,
   input  logic [BW_PERIOD-1:0]   period_i,
   input  logic                   req_i,
   input  logic [31:0]            pc_i,
   input  logic [BW_TAG-1:0]      tag_i,
   input  logic                   flush_i,
   output logic                   stall_o,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [31:0]            out_pc_o,
   output logic [BW_TAG-1:0]      out_tag_o,
   output logic [31:0]            out_interval_o,
   output logic [31:0]            out_time_o,
   output logic [31:0]            count_o,
   output logic [$clog2(N_FIFO):0] fifo_level_o,
   output logic                   flush_done_o
);
   localparam int IW = $clog2(N_TABLE);
   localparam int FW = $clog2(N_FIFO);

   typedef enum logic [1:0] {RUN, EVICT_SCAN, FLUSH} state_t;
   typedef struct packed {
      logic [31:0]       pc;
      logic [BW_TAG-1:0] tag;
      logic [31:0]       interval;
      logic [31:0]       tstamp;
   } rec_t;

   state_t state, state_nx;
   logic [N_TABLE-1:0]             valid_v, match_v, load_v, clr_v;
   logic [N_TABLE-1:0][BW_TAG-1:0] tag_v;
   logic [N_TABLE-1:0][31:0]       pc_v, cnt_v;
   logic [BW_TAG-1:0]  ld_tag, pend_tag;
   logic [31:0]        ld_pc, pend_pc, time_cnt, count_q, max_cnt, hit_cnt_inc;
   logic [15:0]        lfsr, lfsr_nx;
   logic [BW_PERIOD-1:0] samp_cnt, thr;
   logic [IW:0]        scan_idx;
   logic [IW-1:0]      scan_lo, max_idx, flush_idx, hit_idx, free_idx;
   logic               acc, samp, hit_any, free_any, scan_done, flush_step, flush_pend, flush_done_q;
   logic               fifo_full, push, pop;
   rec_t               push_rec, head;
   rec_t               mem [N_FIFO];
   logic [FW-1:0]      wr_ptr, rd_ptr;
   logic [FW:0]        level;

   genvar g;
   generate
      for (g = 0; g < N_TABLE; g++) begin : g_ent
         reuse_sampler_entry #(.BW_TAG(BW_TAG)) u_ent (
            .clk(clock_i), .rst_n(resetn_i), .inc(acc), .load(load_v[g]), .clr(clr_v[g]),
            .ld_tag(ld_tag), .ld_pc(ld_pc), .cmp_tag(tag_i),
            .valid(valid_v[g]), .tag(tag_v[g]), .pc(pc_v[g]), .cnt(cnt_v[g]), .match(match_v[g]));
      end
   endgenerate

   assign fifo_full  = (level == (FW+1)'(N_FIFO));
   assign stall_o    = (state != RUN) | fifo_full;
   assign acc        = req_i & en_i & ~stall_o;
   assign thr        = mode_i ? lfsr[BW_PERIOD-1:0] : period_i;
   assign samp       = acc & (samp_cnt == thr);
   assign lfsr_nx    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign scan_lo    = scan_idx[IW-1:0];
   assign scan_done  = (scan_idx == (IW+1)'(N_TABLE));
   assign flush_step = en_i && (state == FLUSH) && !(valid_v[flush_idx] && fifo_full);
   assign hit_cnt_inc = (cnt_v[hit_idx] == 32'h7FFF_FFFF) ? cnt_v[hit_idx] : cnt_v[hit_idx] + 32'd1;

   // lowest-index hit and free slot; a slot being hit counts as free
   always_comb begin
      hit_any = 1'b0; hit_idx = '0; free_any = 1'b0; free_idx = '0;
      for (int i = N_TABLE-1; i >= 0; i--) begin
         if (match_v[i]) begin hit_any = 1'b1; hit_idx = IW'(i); end
         if (!valid_v[i] || match_v[i]) begin free_any = 1'b1; free_idx = IW'(i); end
      end
   end

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) state <= RUN;
      else           state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         RUN:        if (samp && !free_any) state_nx = EVICT_SCAN;
                     else if (en_i && (flush_i || flush_pend)) state_nx = FLUSH;
         EVICT_SCAN: if (en_i && scan_done && !fifo_full) state_nx = RUN;
         FLUSH:      if (flush_step && flush_idx == IW'(N_TABLE-1)) state_nx = RUN;
         default:    state_nx = RUN;
      endcase
   end

   always_comb begin
      push = 1'b0; push_rec = '0; clr_v = '0; load_v = '0; ld_tag = tag_i; ld_pc = pc_i;
      case (state)
         RUN: begin
            if (acc && hit_any) begin
               push = 1'b1;
               push_rec = '{pc: pc_v[hit_idx], tag: tag_v[hit_idx], interval: hit_cnt_inc, tstamp: time_cnt};
               clr_v[hit_idx] = 1'b1;
            end
            if (samp && free_any) load_v[free_idx] = 1'b1;
         end
         EVICT_SCAN: if (en_i && scan_done && !fifo_full) begin
            push = 1'b1;
            push_rec = '{pc: pc_v[max_idx], tag: tag_v[max_idx], interval: 32'd0 - max_cnt, tstamp: time_cnt};
            load_v[max_idx] = 1'b1;
            ld_tag = pend_tag; ld_pc = pend_pc;
         end
         FLUSH: if (flush_step && valid_v[flush_idx]) begin
            push = 1'b1;
            push_rec = '{pc: pc_v[flush_idx], tag: tag_v[flush_idx], interval: 32'd0 - cnt_v[flush_idx], tstamp: time_cnt};
            clr_v[flush_idx] = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         time_cnt <= '0; count_q <= '0; samp_cnt <= '0; lfsr <= 16'hACE1;
         pend_tag <= '0; pend_pc <= '0; scan_idx <= '0; max_cnt <= '0; max_idx <= '0;
         flush_idx <= '0; flush_pend <= 1'b0; flush_done_q <= 1'b0;
      end else begin
         flush_done_q <= (state == FLUSH) && (state_nx == RUN);
         if (acc) begin
            time_cnt <= time_cnt + 32'd1;
            if (samp) begin samp_cnt <= '0; lfsr <= lfsr_nx; end
            else        samp_cnt <= samp_cnt + BW_PERIOD'(1);
            if (hit_any) count_q <= count_q + 32'd1;
         end
         // a flush arriving with an eviction-triggering reference is served after the eviction
         if (state == RUN && en_i) flush_pend <= (flush_i || flush_pend) && (state_nx != FLUSH);
         if (state == RUN && state_nx == EVICT_SCAN) begin
            pend_tag <= tag_i; pend_pc <= pc_i;
            scan_idx <= '0; max_cnt <= '0; max_idx <= '0;
         end
         if (state == EVICT_SCAN && en_i) begin
            if (!scan_done) begin
               if (scan_idx == '0 || cnt_v[scan_lo] > max_cnt) begin
                  max_cnt <= cnt_v[scan_lo]; max_idx <= scan_lo;
               end
               scan_idx <= scan_idx + (IW+1)'(1);
            end else if (!fifo_full) count_q <= count_q + 32'd1;
         end
         if (state == RUN && state_nx == FLUSH) flush_idx <= '0;
         else if (flush_step)                   flush_idx <= flush_idx + IW'(1);
      end
   end

   assign pop = out_valid_o & out_ready_i;

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         wr_ptr <= '0; rd_ptr <= '0; level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FW'(1);
         if (pop)  rd_ptr <= rd_ptr + FW'(1);
         level <= level + (FW+1)'(push) - (FW+1)'(pop);
      end
   end

   always_ff @(posedge clock_i) begin
      if (push) mem[wr_ptr] <= push_rec;
   end

   assign head           = mem[rd_ptr];
   assign out_valid_o    = (level != '0);
   assign out_pc_o       = head.pc;
   assign out_tag_o      = head.tag;
   assign out_interval_o = head.interval;
   assign out_time_o     = head.tstamp;
   assign count_o        = count_q;
   assign fifo_level_o   = level;
   assign flush_done_o   = flush_done_q;
endmodule

// File: tb/tb_reuse_sampler_param.sv
// Directed bench for reuse_sampler_param (N_TABLE=4): hit records, eviction,
// flush walk, FIFO backpressure, LFSR-driven sampling and reset mid-eviction.

module tb_reuse_sampler_param;
   localparam int NT = 4, BT = 20, NF = 16, BP = 9;

   logic clock = 1'b0, resetn = 1'b0, en = 1'b0, mode = 1'b0, req = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [BP-1:0] period = '0;
   logic [31:0]   pc = '0;
   logic [BT-1:0] tag = '0;
   logic          stall_o, out_valid_o, flush_done_o;
   logic [31:0]   out_pc_o, out_interval_o, out_time_o, count_o;
   logic [BT-1:0] out_tag_o;
   logic [$clog2(NF):0] fifo_level_o;

   typedef struct {
      logic [31:0] pc; logic [BT-1:0] tag; logic [31:0] iv; logic [31:0] t;
   } rec_t;
   rec_t q[$];
   int n_chk = 0, n_fail = 0;

   reuse_sampler_param #(.N_TABLE(NT), .BW_TAG(BT), .N_FIFO(NF), .BW_PERIOD(BP)) dut (
      .clock_i(clock), .resetn_i(resetn), .en_i(en), .mode_i(mode), .period_i(period),
      .req_i(req), .pc_i(pc), .tag_i(tag), .flush_i(flush), .stall_o(stall_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_pc_o(out_pc_o),
      .out_tag_o(out_tag_o), .out_interval_o(out_interval_o), .out_time_o(out_time_o),
      .count_o(count_o), .fifo_level_o(fifo_level_o), .flush_done_o(flush_done_o));

   always #5 clock = ~clock;

   always @(negedge clock)
      if (resetn && out_valid_o && out_ready)
         q.push_back('{pc: out_pc_o, tag: out_tag_o, iv: out_interval_o, t: out_time_o});

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic chk_rec(input string nm, input int i, input logic [31:0] epc,
                          input logic [BT-1:0] etag, input logic [31:0] eiv, input logic [31:0] et);
      chk({nm, "_present"}, 64'(q.size() > i), 64'd1);
      if (q.size() > i) begin
         chk({nm, "_pc"},  q[i].pc,  epc);
         chk({nm, "_tag"}, q[i].tag, etag);
         chk({nm, "_iv"},  q[i].iv,  eiv);
         chk({nm, "_t"},   q[i].t,   et);
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0; req = 1'b0; flush = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_valid", out_valid_o, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_done", flush_done_o, 0);
      chk("rst_count", count_o, 0);
      chk("rst_level", fifo_level_o, 0);
      q.delete();
      resetn = 1'b1;
      @(negedge clock);
   endtask

   // called at a negedge; returns at the negedge after the accepting posedge
   task automatic send(input logic [BT-1:0] t, input logic [31:0] p);
      int n = 0;
      tag = t; pc = p; req = 1'b1;
      while (stall_o && n < 100) begin @(negedge clock); n++; end
      if (n >= 100) chk("send_timeout", 64'(n), 64'd0);
      @(negedge clock);
      req = 1'b0;
   endtask

   task automatic set_ready(input logic v);
      @(posedge clock); #1 out_ready = v;
   endtask

   initial begin
      int n;
      en = 1'b1; out_ready = 1'b1; mode = 1'b0; period = '0;

      // re-reference of A after one intervening reference
      do_reset();
      send(20'h0A, 32'h10); send(20'h0B, 32'h20); send(20'h0A, 32'h10);
      repeat (2) @(negedge clock);
      chk("t1_nrec", q.size(), 1);
      chk_rec("t1_rec", 0, 32'h10, 20'h0A, 32'd2, 32'd2);
      chk("t1_count", count_o, 1);

      // full table: fifth distinct tag forces an eviction scan
      do_reset();
      for (int i = 0; i < 5; i++) send(BT'(20'h100 + i), 32'h1000 + 32'(4 * i));
      n = 0;
      while (stall_o && n < 50) begin n++; @(negedge clock); end
      chk("t2_stall_cycles", n, NT + 1);
      repeat (2) @(negedge clock);
      chk("t2_nrec", q.size(), 1);
      chk_rec("t2_evict", 0, 32'h1000, 20'h100, 32'hFFFF_FFFC, 32'd5);
      chk("t2_count", count_o, 1);
      send(20'h104, 32'h1010);
      repeat (2) @(negedge clock);
      chk_rec("t2_resident", 1, 32'h1010, 20'h104, 32'd1, 32'd5);
      chk("t2_count2", count_o, 2);

      // counters 5,3,1 then flush
      do_reset();
      period = 0; send(20'hA1, 32'h200);
      period = 1;
      send(20'h301, 32'h0); send(20'hB2, 32'h204); send(20'h303, 32'h0);
      send(20'hC3, 32'h208); send(20'h305, 32'h0);
      flush = 1'b1; @(negedge clock); flush = 1'b0;
      n = 0;
      while (!flush_done_o && n < 30) begin n++; @(negedge clock); end
      chk("t3_done", flush_done_o, 1);
      chk("t3_latency", n, NT);
      @(negedge clock);
      chk("t3_done_pulse", flush_done_o, 0);
      chk("t3_nrec", q.size(), 3);
      chk_rec("t3_a", 0, 32'h200, 20'hA1, 32'hFFFF_FFFB, 32'd6);
      chk_rec("t3_b", 1, 32'h204, 20'hB2, 32'hFFFF_FFFD, 32'd6);
      chk_rec("t3_c", 2, 32'h208, 20'hC3, 32'hFFFF_FFFF, 32'd6);
      flush = 1'b1; @(negedge clock); flush = 1'b0;
      n = 0;
      while (!flush_done_o && n < 30) begin n++; @(negedge clock); end
      chk("t3_done2", flush_done_o, 1);
      chk("t3_empty", q.size(), 3);

      // FIFO backpressure
      out_ready = 1'b0; period = 0;
      do_reset();
      repeat (17) send(20'hAA, 32'h40);
      chk("t4_level", fifo_level_o, NF);
      chk("t4_stall", stall_o, 1);
      chk("t4_count", count_o, 16);
      tag = 20'hAA; req = 1'b1;
      repeat (3) @(negedge clock);
      req = 1'b0;
      chk("t4_blocked", count_o, 16);
      set_ready(1'b1); set_ready(1'b0); @(negedge clock);
      chk("t4_pop1", q.size(), 1);
      chk_rec("t4_first", 0, 32'h40, 20'hAA, 32'd1, 32'd1);
      chk("t4_unstall", stall_o, 0);
      chk("t4_level15", fifo_level_o, NF - 1);
      set_ready(1'b1);
      repeat (20) @(negedge clock);
      chk("t4_drained", q.size(), 16);
      chk_rec("t4_last", 15, 32'h40, 20'hAA, 32'd1, 32'd16);
      chk("t4_level0", fifo_level_o, 0);

      // LFSR thresholds 225, 451, 391 -> samples at t=225, 677, 1069
      do_reset();
      mode = 1'b1; period = 9'd3;
      for (int i = 0; i < 1100; i++) begin
         if (i == 300) begin
            en = 1'b0; tag = 20'h55; req = 1'b1;
            repeat (5) @(negedge clock);
            req = 1'b0; en = 1'b1;
         end
         send(20'h55, 32'h80);
      end
      repeat (3) @(negedge clock);
      chk("t5_nrec", q.size(), 3);
      chk_rec("t5_r0", 0, 32'h80, 20'h55, 32'd1, 32'd226);
      chk_rec("t5_r1", 1, 32'h80, 20'h55, 32'd1, 32'd678);
      chk_rec("t5_r2", 2, 32'h80, 20'h55, 32'd1, 32'd1070);
      chk("t5_count", count_o, 3);

      // reset during the eviction scan
      mode = 1'b0; period = 0;
      do_reset();
      for (int i = 0; i < 5; i++) send(BT'(20'h200 + i), 32'h2000 + 32'(i));
      @(negedge clock);
      chk("t6_in_scan", stall_o, 1);
      resetn = 1'b0;
      #1;
      chk("t6_valid", out_valid_o, 0);
      chk("t6_stall", stall_o, 0);
      chk("t6_done", flush_done_o, 0);
      chk("t6_count", count_o, 0);
      @(negedge clock);
      resetn = 1'b1;
      repeat (10) @(negedge clock);
      chk("t6_norec", q.size(), 0);
      chk("t6_level", fifo_level_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
